// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state, queue-entry and BTB-entry types for the fetch unit
package fetch_pkg;

    // Stored PC/target fields are this wide; the top truncates to its ADDR_W.
    localparam int FETCH_AW = 32;

    localparam logic [1:0] CTR_MIN        = 2'd0;
    localparam logic [1:0] CTR_WEAK_TAKEN = 2'd2;
    localparam logic [1:0] CTR_MAX        = 2'd3;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} fetch_state_t;

    typedef struct packed {
        logic [31:0]         instr;
        logic [FETCH_AW-1:0] pc;
        logic                pred_taken;
        logic [FETCH_AW-1:0] pred_target;
    } q_entry_t;

    typedef struct packed {
        logic                valid;
        logic [FETCH_AW-1:0] tag;
        logic [FETCH_AW-1:0] target;
        logic [1:0]          ctr;
    } btb_entry_t;

endpackage

// File: rtl/fetch_btb.sv
// rtl/fetch_btb.sv - direct-mapped BTB with 2-bit counters; combinational lookup, registered update
module fetch_btb
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              lookup_taken,
    output logic [ADDR_W-1:0] lookup_target,
    input  logic              upd_valid,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [ADDR_W-1:0] upd_target
);
    localparam int IW = $clog2(ENTRIES);

    btb_entry_t          btb_q [ENTRIES];
    btb_entry_t          l_ent, u_ent;
    logic [IW-1:0]       l_idx, u_idx;
    logic [FETCH_AW-1:0] l_tag, u_tag;
    logic                u_hit;

    assign l_idx = lookup_pc[IW+1:2];
    assign u_idx = upd_pc[IW+1:2];
    assign l_tag = FETCH_AW'(lookup_pc >> (IW + 2));
    assign u_tag = FETCH_AW'(upd_pc >> (IW + 2));
    assign l_ent = btb_q[l_idx];
    assign u_ent = btb_q[u_idx];
    assign u_hit = u_ent.valid && (u_ent.tag == u_tag);

    // Lookup reads the array before this cycle's update lands.
    assign lookup_taken  = l_ent.valid && (l_ent.tag == l_tag) && (l_ent.ctr >= CTR_WEAK_TAKEN);
    assign lookup_target = lookup_taken ? ADDR_W'(l_ent.target) : lookup_pc + ADDR_W'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) btb_q[i] <= '0;
        end else if (upd_valid) begin
            if (u_hit) begin
                if (upd_taken) begin
                    btb_q[u_idx].target <= FETCH_AW'(upd_target);
                    if (u_ent.ctr != CTR_MAX) btb_q[u_idx].ctr <= u_ent.ctr + 2'd1;
                end else if (u_ent.ctr != CTR_MIN) begin
                    btb_q[u_idx].ctr <= u_ent.ctr - 2'd1;
                end
            end else if (upd_taken) begin
                btb_q[u_idx] <= '{valid: 1'b1, tag: u_tag, target: FETCH_AW'(upd_target), ctr: CTR_WEAK_TAKEN};
            end
        end
    end

endmodule

// File: rtl/pipelined_fetch_unit.sv
// rtl/pipelined_fetch_unit.sv - single-outstanding fetch FSM with fetch queue; FETCH_BTB_EN enables the BTB
module pipelined_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH       = 4,
    parameter int                BTB_ENTRIES = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic                       mem_gnt,
    input  logic                       mem_rvalid,
    input  logic [31:0]                mem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [ADDR_W-1:0]          out_pc,
    output logic                       out_pred_taken,
    output logic [ADDR_W-1:0]          out_pred_target,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    input  logic                       upd_valid,
    input  logic                       upd_taken,
    input  logic [ADDR_W-1:0]          upd_pc,
    input  logic [ADDR_W-1:0]          upd_target,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);
    localparam int             CW   = $clog2(DEPTH + 1);
    localparam int             PW   = $clog2(DEPTH);
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_pc, pend_pc, pend_target, pred_target;
    logic              pend_taken, pred_taken;
    q_entry_t          queue [DEPTH];
    q_entry_t          head;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count, count_after;
    logic              push, pop;

`ifdef FETCH_BTB_EN
    fetch_btb #(.ADDR_W(ADDR_W), .ENTRIES(BTB_ENTRIES)) u_btb (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_pc    (fetch_pc),
        .lookup_taken (pred_taken),
        .lookup_target(pred_target),
        .upd_valid    (upd_valid),
        .upd_taken    (upd_taken),
        .upd_pc       (upd_pc),
        .upd_target   (upd_target)
    );
`else
    localparam int unused_btb_entries = BTB_ENTRIES;
    logic unused_upd;
    assign unused_upd  = ^{upd_valid, upd_taken, upd_pc, upd_target};
    assign pred_taken  = 1'b0;
    assign pred_target = fetch_pc + ADDR_W'(4);
`endif

    // Redirect outranks both the push of a returning word and a decode pop.
    assign push        = (state == WAIT) && mem_rvalid && !redirect_valid;
    assign pop         = out_valid && out_ready && !redirect_valid;
    assign count_after = count + CW'(push) - CW'(pop);

    assign mem_req         = (state == REQ);
    assign mem_addr        = mem_req ? fetch_pc : '0;
    assign head            = queue[rd_ptr];
    assign out_valid       = (count != '0);
    assign out_instr       = out_valid ? head.instr : '0;
    assign out_pc          = out_valid ? ADDR_W'(head.pc) : '0;
    assign out_pred_taken  = out_valid && head.pred_taken;
    assign out_pred_target = out_valid ? ADDR_W'(head.pred_target) : '0;
    assign q_count         = count;

    always_ff @(posedge clk) begin
        if (push) begin
            queue[wr_ptr] <= '{instr: mem_rdata, pc: FETCH_AW'(pend_pc),
                               pred_taken: pend_taken, pred_target: FETCH_AW'(pend_target)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            pend_pc     <= '0;
            pend_taken  <= 1'b0;
            pend_target <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count_after;
            end

            case (state)
                IDLE: if (!redirect_valid && count < FULL) state <= REQ;
                REQ: begin
                    if (redirect_valid) begin
                        state <= mem_gnt ? DRAIN : IDLE;
                    end else if (mem_gnt) begin
                        pend_pc     <= fetch_pc;
                        pend_taken  <= pred_taken;
                        pend_target <= pred_target;
                        fetch_pc    <= pred_target;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) state <= mem_rvalid ? IDLE : DRAIN;
                    else if (mem_rvalid) state <= (count_after < FULL) ? REQ : IDLE;
                end
                // The queue was cleared on entry, so a slot is free once the stale word is gone.
                DRAIN: if (mem_rvalid) state <= REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipelined_fetch_unit.sv
// tb/tb_pipelined_fetch_unit.sv - directed vector bench for pipelined_fetch_unit
`timescale 1ns/1ps
module tb_pipelined_fetch_unit;
    localparam int          ADDR_W = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] OFS    = 32'hA0A0A0A0;
`ifdef FETCH_BTB_EN
    localparam bit BTB_ON = 1'b1;
`else
    localparam bit BTB_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mem_req, mem_gnt, mem_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata, out_instr;
    logic              out_valid, out_ready, out_pred_taken;
    logic [ADDR_W-1:0] out_pc, out_pred_target, redirect_pc, upd_pc, upd_target;
    logic              redirect_valid, upd_valid, upd_taken;
    logic [2:0]        q_count;

    logic        gnt_en, stray_rv, pend;
    int          lat, wait_cnt;
    logic [31:0] paddr;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    pipelined_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BTB_ENTRIES(16), .RESET_PC('0)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_pred_taken(out_pred_taken),
        .out_pred_target(out_pred_target), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_pc(upd_pc), .upd_target(upd_target),
        .q_count(q_count)
    );

    // Memory: grant in the request cycle, answer lat cycles after the grant cycle.
    assign mem_gnt    = mem_req && gnt_en;
    assign mem_rvalid = (pend && wait_cnt == 0) || stray_rv;
    assign mem_rdata  = paddr + OFS;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0; wait_cnt <= 0; paddr <= '0;
        end else if (mem_req && mem_gnt) begin
            pend <= 1'b1; paddr <= mem_addr; wait_cnt <= lat;
        end else if (pend && wait_cnt != 0) begin
            wait_cnt <= wait_cnt - 1;
        end else begin
            pend <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_valid(input string name, input int budget, output int n);
        n = 0;
        while (!out_valid && n < budget) begin
            step();
            n++;
        end
        chk(name, out_valid, 1);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; redirect_valid = 1'b0; upd_valid = 1'b0; stray_rv = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1; redirect_pc = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic do_update(input logic taken, input logic [31:0] pc, input logic [31:0] tgt);
        upd_valid = 1'b1; upd_taken = taken; upd_pc = pc; upd_target = tgt;
        step();
        upd_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } seq_vec_t;

    initial begin
        seq_vec_t    seq_tab [5];
        int          n, got;
        logic [31:0] exp_pc;

        seq_tab[0] = '{32'h0000_0000, 32'hA0A0_A0A0};
        seq_tab[1] = '{32'h0000_0004, 32'hA0A0_A0A4};
        seq_tab[2] = '{32'h0000_0008, 32'hA0A0_A0A8};
        seq_tab[3] = '{32'h0000_000C, 32'hA0A0_A0AC};
        seq_tab[4] = '{32'h0000_0010, 32'hA0A0_A0B0};

        out_ready = 1'b1; gnt_en = 1'b1; lat = 0; stray_rv = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        upd_valid = 1'b0; upd_taken = 1'b0; upd_pc = '0; upd_target = '0;

        // Reset values
        step(); step();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_q_count", q_count, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_pred_target", out_pred_target, 0);
        rst_n = 1'b1;
        chk("idle_after_release", mem_req, 0);
        step();
        chk("first_req", mem_req, 1);
        chk("first_addr", mem_addr, 0);

        // Sequential stream at one word per two cycles
        for (int i = 0; i < 5; i++) begin
            wait_valid("seq_wait", 8, n);
            if (i > 0) chk("seq_interval", n, 1);
            chk("seq_pc", out_pc, seq_tab[i].pc);
            chk("seq_instr", out_instr, seq_tab[i].instr);
            chk("seq_pred_taken", out_pred_taken, 0);
            chk("seq_pred_target", out_pred_target, seq_tab[i].pc + 32'd4);
            step();
            chk("seq_gap", out_valid, 0);
        end

        // Back-pressure fills the queue, then drains contiguously
        out_ready = 1'b0;
        repeat (20) step();
        chk("bp_q_count", q_count, DEPTH);
        chk("bp_no_req", mem_req, 0);
        chk("bp_head_pc", out_pc, 32'h14);
        out_ready = 1'b1; exp_pc = 32'h14; got = 0;
        for (int k = 0; k < 40 && got < 8; k++) begin
            if (out_valid) begin
                chk("bp_pc", out_pc, exp_pc);
                chk("bp_instr", out_instr, exp_pc + OFS);
                exp_pc += 32'd4;
                got++;
            end
            step();
        end
        chk("bp_resume_count", got, 8);

        // Redirect while WAIT has no response yet -> DRAIN
        gnt_en = 1'b1; lat = 3; out_ready = 1'b0;
        reset_dut();
        repeat (7) step();
        chk("rdw_pre_count", q_count, 1);
        chk("rdw_pre_noreq", mem_req, 0);
        lat = 0;
        do_redirect(32'h100);
        chk("rdw_valid", out_valid, 0);
        chk("rdw_q_count", q_count, 0);
        chk("rdw_drain_noreq", mem_req, 0);
        n = 0;
        while (!mem_req && n < 10) begin step(); n++; end
        chk("rdw_req", mem_req, 1);
        chk("rdw_req_addr", mem_addr, 32'h100);
        wait_valid("rdw_wait", 10, n);
        chk("rdw_pc", out_pc, 32'h100);
        chk("rdw_instr", out_instr, 32'hA0A0_A1A0);
        chk("rdw_count_one", q_count, 1);

        // Redirect while REQ is not granted; address holds meanwhile
        gnt_en = 1'b0; out_ready = 1'b1;
        reset_dut();
        step(); step(); step();
        chk("hold_req", mem_req, 1);
        chk("hold_addr", mem_addr, 0);
        do_redirect(32'h200);
        chk("rdq_withdrawn", mem_req, 0);
        gnt_en = 1'b1;
        step();
        chk("rdq_req", mem_req, 1);
        chk("rdq_addr", mem_addr, 32'h200);
        wait_valid("rdq_wait", 10, n);
        chk("rdq_pc", out_pc, 32'h200);

        // Redirect in the same cycle as rvalid: response discarded
        gnt_en = 1'b1; lat = 0; out_ready = 1'b0;
        reset_dut();
        step(); step();
        do_redirect(32'h40);
        chk("rdr_q_count", q_count, 0);
        chk("rdr_valid", out_valid, 0);
        step();
        chk("rdr_req", mem_req, 1);
        chk("rdr_addr", mem_addr, 32'h40);
        wait_valid("rdr_wait", 10, n);
        chk("rdr_pc", out_pc, 32'h40);
        chk("rdr_instr", out_instr, 32'hA0A0_A0E0);

        // Reset mid-WAIT; a stray rvalid afterwards is ignored
        gnt_en = 1'b1; lat = 0; out_ready = 1'b0;
        reset_dut();
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        chk("mrst_mem_req", mem_req, 0);
        chk("mrst_mem_addr", mem_addr, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_q_count", q_count, 0);
        chk("mrst_out_instr", out_instr, 0);
        step();
        gnt_en = 1'b0; stray_rv = 1'b1;
        rst_n = 1'b1;
        step(); step();
        stray_rv = 1'b0;
        chk("mrst_stray_q", q_count, 0);
        chk("mrst_req", mem_req, 1);
        chk("mrst_addr", mem_addr, 0);
        gnt_en = 1'b1;
        wait_valid("mrst_wait", 10, n);
        chk("mrst_pc", out_pc, 0);

        // Two taken updates, then fetch the branch
        gnt_en = 1'b0; out_ready = 1'b1;
        reset_dut();
        do_update(1'b1, 32'h20, 32'h100);
        do_update(1'b1, 32'h20, 32'h100);
        do_redirect(32'h20);
        gnt_en = 1'b1;
        wait_valid("btb_wait", 10, n);
        chk("btb_pc", out_pc, 32'h20);
        chk("btb_instr", out_instr, 32'hA0A0_A0C0);
        chk("btb_taken", out_pred_taken, BTB_ON ? 1 : 0);
        chk("btb_target", out_pred_target, BTB_ON ? 32'h100 : 32'h24);
        step();
        wait_valid("btb_wait2", 10, n);
        chk("btb_next_pc", out_pc, BTB_ON ? 32'h100 : 32'h24);

        // Allocate at counter 2, two not-taken updates bring it to 0
        gnt_en = 1'b0;
        reset_dut();
        do_update(1'b1, 32'h20, 32'h100);
        do_update(1'b0, 32'h20, 32'h100);
        do_update(1'b0, 32'h20, 32'h100);
        do_redirect(32'h20);
        gnt_en = 1'b1;
        wait_valid("nt_wait", 10, n);
        chk("nt_pc", out_pc, 32'h20);
        chk("nt_taken", out_pred_taken, 0);
        chk("nt_target", out_pred_target, 32'h24);
        step();
        wait_valid("nt_wait2", 10, n);
        chk("nt_next_pc", out_pc, 32'h24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
